// File: rtl/spi_master.sv
// SPI mode-0 master, 8-bit frames, MSB first by default.
// Define SPI_MASTER_LSB_FIRST_EN to shift bit 0 first on both mosi and miso.
`timescale 1ns/1ps
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} state_t;

    state_t        state;
    logic [CW-1:0] half_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          half_end;

    assign half_end = (half_cnt == DIV_LAST);

`ifdef SPI_MASTER_LSB_FIRST_EN
    function automatic logic first_bit(input logic [7:0] d);
        return d[0];
    endfunction

    function automatic logic [7:0] shift_tx(input logic [7:0] d);
        return {1'b0, d[7:1]};
    endfunction

    function automatic logic [7:0] shift_rx(input logic [7:0] sr, input logic b);
        return {b, sr[7:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [7:0] d);
        return d[7];
    endfunction

    function automatic logic [7:0] shift_tx(input logic [7:0] d);
        return {d[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] shift_rx(input logic [7:0] sr, input logic b);
        return {sr[6:0], b};
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr    <= shift_tx(tx_data);
                        mosi     <= first_bit(tx_data);
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        rx_sr    <= '0;
                        state    <= SETUP;
                    end
                end
                // The edge that ends SETUP is also the first sclk rise.
                SETUP: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        sclk     <= 1'b1;
                        rx_sr    <= shift_rx(rx_sr, miso);
                        state    <= TRANSFER;
                    end else begin
                        half_cnt <= half_cnt + CW'(1);
                    end
                end
                TRANSFER: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sr <= shift_rx(rx_sr, miso);
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                mosi  <= 1'b0;
                                state <= HOLD;
                            end else begin
                                mosi  <= first_bit(tx_sr);
                                tx_sr <= shift_tx(tx_sr);
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        ss_n     <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rx_data  <= rx_sr;
                        state    <= DONE;
                    end else begin
                        half_cnt <= half_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system-clock cycles per SCLK half-period; legal values are 1 or more.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on the rising edge of clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, transfer request, sampled only in IDLE.
REQ-005 SHALL have port tx_data, input, 8, byte to transmit, latched when start is accepted.
REQ-006 SHALL have port rx_data, output reg, 8, last received byte.
REQ-007 SHALL have port busy, output reg, 1, high while a frame is in progress.
REQ-008 SHALL have port done, output reg, 1, one-cycle pulse marking frame completion.
REQ-009 SHALL have port sclk, output reg, 1, SPI serial clock.
REQ-010 SHALL have port ss_n, output reg, 1, active-low slave select.
REQ-011 SHALL have port mosi, output reg, 1, master-out serial data.
REQ-012 SHALL have port miso, input, 1, master-in serial data.

Function
REQ-013 SHALL implement SPI mode 0 (CPOL=0, CPHA=0) with 8-bit frames, MSB first by default.
REQ-014 SHALL use FSM states IDLE, SETUP, TRANSFER, HOLD and DONE, with the transitions defined in REQ-015 to REQ-020.
REQ-015 SHALL accept start in IDLE at edge T: latch tx_data, and at T+1 drive ss_n=0, busy=1, mosi=first bit, then enter SETUP.
REQ-016 SHALL keep sclk=0 in SETUP for CLK_DIV cycles, then enter TRANSFER.
REQ-017 SHALL toggle sclk every CLK_DIV cycles in TRANSFER; first rise at T+1+CLK_DIV.
REQ-018 SHALL sample miso into the receive shift register at the clk edge that drives sclk high.
REQ-019 SHALL drive the next mosi bit at the clk edge that drives sclk low; after the 8th fall, mosi SHALL be 0 and the FSM SHALL enter HOLD.
REQ-020 SHALL keep ss_n=0 and sclk=0 in HOLD for CLK_DIV cycles; then, at edge T+1+17*CLK_DIV, it SHALL set ss_n=1, busy=0, done=1, load rx_data, and enter DONE.
REQ-021 SHALL occupy DONE for exactly one cycle, then return to IDLE with done=0.
REQ-022 SHALL produce exactly 8 sclk rising edges per frame; sclk SHALL be 0 whenever ss_n=1.
REQ-023 SHALL ignore start and tx_data changes outside IDLE; frame content SHALL come only from the latched byte.
REQ-024 SHALL hold ss_n high for at least 2 cycles between frames: DONE plus one IDLE cycle.
REQ-025 SHALL keep rx_data unchanged except at the DONE load.
REQ-026 SHALL use a half-period counter of at least clog2(CLK_DIV)+1 bits and a 4-bit bit counter; neither SHALL wrap within a frame.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-frame, asynchronously force: IDLE, sclk=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=0x00, all counters and shift registers to 0.
REQ-028 SHALL NOT emit done for a frame aborted by reset, and SHALL accept a new start on the first edge after rst_n rises.

Configuration
REQ-029 SHALL honour macro SPI_MASTER_LSB_FIRST_EN: when defined, mosi SHALL send bit 0 first and the first received miso bit SHALL land in rx_data[0].
REQ-030 SHALL, when SPI_MASTER_LSB_FIRST_EN is undefined, transmit and receive MSB first, compatible with the existing mode-0 slave.

Verification
REQ-031 SHALL cover: CLK_DIV=4, start with tx_data=0xA5, slave model returning 0x3C -> mosi at the 8 rises reads 1,0,1,0,0,1,0,1; rx_data=0x3C; done pulse at T+69; ss_n low for cycles T+1..T+68.
REQ-032 SHALL cover: start held high and tx_data changed to 0xFF mid-frame -> frame still sends 0xA5; exactly one done; next ss_n fall occurs 2 cycles after done.
REQ-033 SHALL cover: back-to-back frames 0x81 then 0x7E against the slave model -> the slave's rx_data reads 0x81 then 0x7E; ss_n high for exactly 2 cycles between frames.
REQ-034 SHALL cover: rst_n pulsed low after the 3rd sclk rise -> outputs at reset values immediately, no done; a following start of 0x55 completes normally.
REQ-035 SHALL cover: CLK_DIV=1, tx_data=0xC3, miso tied 1 -> sclk period 2 cycles; done at T+18; rx_data=0xFF.
REQ-036 SHALL cover: SPI_MASTER_LSB_FIRST_EN defined, tx_data=0x01, miso sequence 1,0,0,0,0,0,0,0 -> first mosi bit 1; rx_data=0x01.
